pll_clken_gen: RTL and testbench



---
 rtl/pll_clken_pkg.sv | 5 +
 rtl/pll_clken_ch.sv | 48 ++++
 rtl/pll_clken_gen.sv | 68 ++++++
 tb/tb_pll_clken_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_clken_pkg.sv
// pll_clken_pkg: shared types and defaults for the PLL clock-enable generator.
package pll_clken_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  localparam int DIV_W_DEF = 16;
endpackage

// File: rtl/pll_clken_ch.sv
// pll_clken_ch: one clock-enable channel with shadowed divide/phase; phase logic only under PLL_CLKEN_PHASE_EN.
module pll_clken_ch
  import pll_clken_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             keep,
  input  logic             enter,
  input  logic             wr,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             clken
);
  logic [DIV_W-1:0] d, sh_d, cnt, d_eff, start;
  logic wrap;
  assign d_eff = (d == '0) ? DIV_W'(1) : d;
  assign wrap = cnt == d_eff - DIV_W'(1);
`ifdef PLL_CLKEN_PHASE_EN
  logic [DIV_W-1:0] sh_p, sh_eff;
  assign sh_eff = (sh_d == '0) ? DIV_W'(1) : sh_d;
  assign start = (sh_p >= sh_eff) ? '0 : sh_p;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) sh_p <= '0;
    else if (wr) sh_p <= phase;
`else
  logic unused_phase;
  assign unused_phase = ^phase;
  assign start = '0;
`endif
  // a write landing on the wrap cycle is forwarded so it applies at that wrap
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      d     <= DIV_W'(DEFAULT_DIV);
      sh_d  <= DIV_W'(DEFAULT_DIV);
      cnt   <= '0;
      clken <= 1'b0;
    end else begin
      if (wr) sh_d <= div;
      if (!run) d <= sh_d;
      else if (wrap) d <= wr ? div : sh_d;
      cnt   <= enter ? start : run ? (wrap ? '0 : cnt + DIV_W'(1)) : cnt;
      clken <= keep & wrap;
    end
endmodule

// File: rtl/pll_clken_gen.sv
// pll_clken_gen: PLL lock qualifier, settle-timed reset release and NUM_CH clock-enable strobes.
// Define PLL_CLKEN_PHASE_EN to build per-channel start phases.
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int SETTLE_CYCLES = 1024,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int SC_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              lock_lost_clr,
  output logic [NUM_CH-1:0] clken,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              lock_lost
);
  logic lk_m, lk_s;
  state_t state, nx;
  logic [SC_W-1:0] scnt;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) {lk_s, lk_m} <= 2'b00;
    else {lk_s, lk_m} <= {lk_m, pll_locked};
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_LOCK;
      scnt  <= '0;
    end else begin
      state <= nx;
      scnt  <= (state == SETTLE) ? scnt + SC_W'(1) : '0;
    end
  always_comb
    nx = !lk_s ? WAIT_LOCK :
         (state == WAIT_LOCK) ? SETTLE :
         (state == SETTLE && scnt == SC_W'(SETTLE_CYCLES - 1)) ? RUN : state;
  // outputs are registered from the next state so they move with the state register
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      ready     <= 1'b0;
      sys_rst_n <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      ready     <= nx == RUN;
      sys_rst_n <= nx == RUN;
      lock_lost <= (state == RUN && nx == WAIT_LOCK) | (lock_lost & ~lock_lost_clr);
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_clken_ch #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .refclk(refclk),
      .rst_n (rst_n),
      .run   (state == RUN),
      .keep  (state == RUN && nx == RUN),
      .enter (state != RUN && nx == RUN),
      .wr    (cfg_wr && cfg_ch == CH_W'(i)),
      .div   (cfg_div),
      .phase (cfg_phase),
      .clken (clken[i])
    );
  end
endmodule

// File: tb/tb_pll_clken_gen.sv
// tb_pll_clken_gen: directed bench for pll_clken_gen (3 channels, 16-cycle settle, default divide 2).
module tb_pll_clken_gen;
  localparam int NUM_CH = 3;
  localparam int DIV_W = 8;
  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [DIV_W-1:0] cfg_phase = '0;
  logic lock_lost_clr = 1'b0;
  logic [NUM_CH-1:0] clken;
  logic sys_rst_n, ready, lock_lost;
  int checks = 0;
  int errors = 0;

  pll_clken_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .SETTLE_CYCLES(16), .DEFAULT_DIV(2)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .lock_lost_clr(lock_lost_clr), .clken(clken), .sys_rst_n(sys_rst_n),
    .ready(ready), .lock_lost(lock_lost)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wr(input int ch, input int dv, input int ph);
    cfg_wr = 1'b1;
    cfg_ch = 2'(ch);
    cfg_div = DIV_W'(dv);
    cfg_phase = DIV_W'(ph);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic next_strobe(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!clken[ch] && n < 64);
  endtask

  task automatic wait_ready(input logic lvl, output int n);
    n = 0;
    while (ready !== lvl && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int f0, f1;
    logic bad;
    logic [5:0] pat;
    logic [4:0] hi;
    #23;
    check("rst_clken", 32'(clken), 0);
    check("rst_sys_rst_n", 32'(sys_rst_n), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    pll_locked = 1'b1;
    n = 0;
    bad = 1'b0;
    while (!sys_rst_n && n < 40) begin
      tick();
      n++;
      if (!sys_rst_n && clken != '0) bad = 1'b1;
    end
    check("release_latency_in_18_19", 32'(n >= 18 && n <= 19), 1);
    check("ready_with_release", 32'(ready), 1);
    check("clken_low_before_run", 32'(bad), 0);
    for (int c = 0; c < 6; c++) begin
      pat[c] = clken[0];
      tick();
    end
    check("default_div2_pattern", 32'(pat), 32'b010100);

    wr(0, 4, 0);
    next_strobe(0, n);
    next_strobe(0, n);
    next_strobe(0, n);
    check("div4_period_a", n, 4);
    next_strobe(0, n);
    check("div4_period_b", n, 4);
    tick();
    wr(0, 6, 0);
    next_strobe(0, n);
    check("div6_old_period_completes", n, 2);
    next_strobe(0, n);
    check("div6_period_a", n, 6);
    wr(3, 2, 0);
    next_strobe(0, n);
    next_strobe(0, n);
    check("out_of_range_no_change", n, 6);
    next_strobe(1, n);
    next_strobe(1, n);
    check("ch1_default_period", n, 2);

    wr(0, 1, 0);
    next_strobe(0, n);
    next_strobe(0, n);
    for (int c = 0; c < 5; c++) begin
      hi[c] = clken[0];
      tick();
    end
    check("div1_constant_high", 32'(hi), 32'b11111);
    wr(0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      hi[c] = clken[0];
      tick();
    end
    check("div0_constant_high", 32'(hi), 32'b11111);

    wr(0, 4, 0);
    wr(1, 4, 2);
    repeat (10) tick();
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n && n < 10) begin
      tick();
      n++;
    end
    check("loss_latency_le_3", 32'(n >= 2 && n <= 3), 1);
    check("loss_ready", 32'(ready), 0);
    check("loss_clken", 32'(clken), 0);
    check("loss_lock_lost", 32'(lock_lost), 1);
    repeat (3) tick();
    check("lock_lost_sticky", 32'(lock_lost), 1);
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("lock_lost_cleared", 32'(lock_lost), 0);

    pll_locked = 1'b1;
    wait_ready(1'b1, n);
    check("relock_ready", 32'(ready), 1);
    f0 = -1;
    f1 = -1;
    for (int c = 0; c < 8; c++) begin
      if (clken[0] && f0 < 0) f0 = c;
      if (clken[1] && f1 < 0) f1 = c;
      tick();
    end
    check("ch0_first_strobe", f0, 4);
`ifdef PLL_CLKEN_PHASE_EN
    check("ch1_first_strobe_phase2", f1, 2);
`else
    check("ch1_first_strobe_no_phase", f1, 4);
`endif

    lock_lost_clr = 1'b1;
    pll_locked = 1'b0;
    wait_ready(1'b0, n);
    check("setclr_drop_seen", 32'(ready), 0);
    check("set_wins_over_clear", 32'(lock_lost), 1);
    tick();
    check("clear_after_set", 32'(lock_lost), 0);
    lock_lost_clr = 1'b0;

    pll_locked = 1'b1;
    wait_ready(1'b1, n);
    check("relock2_ready", 32'(ready), 1);
    wr(0, 7, 0);
    next_strobe(0, n);
    next_strobe(0, n);
    next_strobe(0, n);
    check("div7_period", n, 7);
    lock_lost_clr = 1'b1;
    pll_locked = 1'b0;
    wait_ready(1'b0, n);
    lock_lost_clr = 1'b0;
    pll_locked = 1'b1;
    wait_ready(1'b1, n);
    repeat (3) tick();
    pll_locked = 1'b0;
    repeat (4) tick();
    pll_locked = 1'b1;
    wait_ready(1'b1, n);
    next_strobe(0, n);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_clken", 32'(clken), 0);
    check("async_rst_sys_rst_n", 32'(sys_rst_n), 0);
    check("async_rst_ready", 32'(ready), 0);
    check("async_rst_lock_lost", 32'(lock_lost), 0);
    tick();
    rst_n = 1'b1;
    wait_ready(1'b1, n);
    check("post_rst_ready", 32'(ready), 1);
    next_strobe(0, n);
    check("post_rst_first_strobe", n, 2);
    next_strobe(0, n);
    check("post_rst_default_div", n, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
